// File: rtl/traffic_cmd_decoder.sv
// rtl/traffic_cmd_decoder.sv - framed byte-stream command decoder feeding traffic_lights
module traffic_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2000,
    parameter logic [3:0]  SYNC_NIBBLE    = 4'hA
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic [2:0]  cmd_type_o,
    output logic [15:0] cmd_data_o,
    output logic        cmd_valid_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        DATA_HI,
        DATA_LO,
        EMIT
    } state_t;

    localparam int unsigned   TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_SYNC    = 2'd0;
    localparam logic [1:0] ERR_TYPE    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ZERO    = 2'd3;

    state_t        state_q, state_d;
    logic [2:0]    type_q, type_d;
    logic [7:0]    msb_q, msb_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    cmd_type_q, cmd_type_d;
    logic [15:0]   cmd_data_q, cmd_data_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          accept;
    logic          raise_err;
    logic [1:0]    raise_code;

    // Ready is gated by reset directly so nothing is consumed while reset is held.
    assign byte_ready_o = !srst_i && (state_q != EMIT);
    assign accept       = byte_valid_i && byte_ready_o;

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        msb_d      = msb_q;
        timer_d    = timer_q;
        cmd_type_d = cmd_type_q;
        cmd_data_d = cmd_data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        err_cnt_d  = err_cnt_q;
        raise_err  = 1'b0;
        raise_code = ERR_SYNC;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (accept) begin
                    if ((byte_data_i[7:4] != SYNC_NIBBLE) || byte_data_i[3]) begin
                        raise_err  = 1'b1;
                        raise_code = ERR_SYNC;
                    end else if (byte_data_i[2:0] >= 3'd6) begin
                        raise_err  = 1'b1;
                        raise_code = ERR_TYPE;
                    end else if (byte_data_i[2:0] <= 3'd2) begin
                        cmd_type_d = byte_data_i[2:0];
                        cmd_data_d = '0;
                        state_d    = EMIT;
                    end else begin
                        type_d  = byte_data_i[2:0];
                        state_d = DATA_HI;
                    end
                end
            end

            DATA_HI, DATA_LO: begin
                if (accept) begin
                    timer_d = '0;
                    if (state_q == DATA_HI) begin
                        msb_d   = byte_data_i;
                        state_d = DATA_LO;
                    end else if ({msb_q, byte_data_i} == 16'd0) begin
                        raise_err  = 1'b1;
                        raise_code = ERR_ZERO;
                        state_d    = IDLE;
                    end else begin
                        cmd_type_d = type_q;
                        cmd_data_d = {msb_q, byte_data_i};
                        state_d    = EMIT;
                    end
                end else if (timer_q == TLAST) begin
                    // A byte arriving on this very cycle takes the branch above instead.
                    timer_d    = '0;
                    raise_err  = 1'b1;
                    raise_code = ERR_TIMEOUT;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            EMIT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (raise_err) begin
            err_d      = 1'b1;
            err_code_d = raise_code;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            type_q     <= '0;
            msb_q      <= '0;
            timer_q    <= '0;
            cmd_type_q <= '0;
            cmd_data_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            msb_q      <= msb_d;
            timer_q    <= timer_d;
            cmd_type_q <= cmd_type_d;
            cmd_data_q <= cmd_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign cmd_valid_o = (state_q == EMIT);
    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: doc/traffic_cmd_decoder.md
Name: traffic_cmd_decoder

Overview:
- Upstream stage of traffic_lights.
- Takes a byte stream with valid/ready handshake, from a UART RX or host bridge, and assembles framed commands.
- Drives traffic_lights' cmd_type_i / cmd_valid_i / cmd_data_i with single-cycle command pulses.
- Rejects malformed, truncated or out-of-range frames and reports them through an error pulse and a saturating error counter.

Parameters:
- TIMEOUT_CYCLES, 2000, idle cycles allowed between bytes of one frame before the frame is aborted (1 s at 2 kHz). Minimum 2.
- SYNC_NIBBLE, 4'hA, required value of header bits [7:4].

Ports:
- clk_i  input  1  system clock
- srst_i  input  1  reset; synchronous, active-high
- byte_data_i  input  8  incoming byte
- byte_valid_i  input  1  byte_data_i valid
- byte_ready_o  output  1  decoder can accept a byte; a transfer occurs when valid && ready
- cmd_type_o  output  3  command type, to traffic_lights cmd_type_i
- cmd_data_o  output  16  command data, to traffic_lights cmd_data_i
- cmd_valid_o  output  1  one-cycle command strobe, to traffic_lights cmd_valid_i
- err_o  output  1  one-cycle pulse per rejected frame
- err_code_o  output  2  cause of the last error: 0 bad sync, 1 bad type, 2 timeout, 3 zero data
- err_cnt_o  output  8  count of rejected frames, saturates at 255

Behaviour:
- Reset values: byte_ready_o=0 while srst_i=1 and 1 on the first cycle after reset; all other outputs 0; FSM in IDLE; timer 0.
- Reset mid-frame discards the partial frame with no err_o.
- Frame format:
  - Header bits [7:4] = SYNC_NIBBLE, bit [3] = 0, bits [2:0] = type.
  - Types 0 (normal), 1 (off), 2 (manual yellow) are one-byte frames.
  - Types 3, 4, 5 (red, yellow, green durations) are followed by data MSB then data LSB.
  - Types 6 and 7 are illegal.
- FSM states: IDLE, DATA_HI, DATA_LO, EMIT.
  - IDLE, header accepted:
    - Sync nibble wrong or bit3=1 -> error code 0, stay IDLE.
    - Type 6/7 -> error code 1, stay IDLE.
    - Type 0..2 -> EMIT.
    - Type 3..5 -> DATA_HI.
  - DATA_HI, byte accepted: capture MSB -> DATA_LO.
  - DATA_LO, byte accepted: capture LSB.
    - 16-bit data == 0 -> error code 3, go IDLE.
    - Otherwise -> EMIT.
  - EMIT lasts one cycle: byte_ready_o=0, cmd_valid_o=1, then IDLE.
- Command latency: cmd_valid_o is high exactly one cycle after the cycle the final byte (header or LSB) is accepted.
- Command output registers:
  - cmd_type_o and cmd_data_o update in the same cycle as the cmd_valid_o pulse and hold until the next command.
  - cmd_data_o = 0 for types 0..2.
  - No command output changes on an error.
- byte_ready_o = 1 in IDLE, DATA_HI and DATA_LO; 0 in EMIT and during reset. Bytes presented while ready=0 are not consumed.
- Timeout:
  - Active in DATA_HI and DATA_LO only.
  - The timer clears on every accepted byte and increments on every cycle without one.
  - On the TIMEOUT_CYCLES-th consecutive idle cycle, the frame is aborted: go IDLE, error code 2.
  - A byte accepted on that same cycle wins; the frame continues and no timeout occurs.
- Errors:
  - err_o pulses the cycle after the rejecting event.
  - err_code_o updates in the same cycle as the err_o pulse and holds.
  - err_cnt_o increments in the same cycle as err_o and stays at 255 once reached.
- Header bytes are not resynchronised inside a frame: bytes in DATA_HI/DATA_LO are always treated as data.
- Mode checks (e.g. durations only accepted in manual yellow) belong to traffic_lights. The decoder forwards every well-formed frame.

Test Plan:
- Reset held 2 cycles, then byte 8'hA1 sent -> byte_ready_o=1 after reset; one cycle after acceptance cmd_valid_o=1 for 1 cycle with type=1, data=0.
- Stream A3,00,64 then A4,00,C8 then A5,01,2C back-to-back -> three pulses: (3,100), (4,200), (5,300). Each pulse is one cycle after its LSB; ready=0 in the emit cycles; no bytes lost.
- Bytes B0, then A8, then A6 -> three err_o pulses with codes 0, 0, 1; err_cnt_o=3; no cmd_valid_o.
- TIMEOUT_CYCLES=8; send A3,00 then idle -> on the 8th idle cycle FSM returns to IDLE; err_o/code 2 one cycle later. A repeat where the LSB arrives on idle cycle 8 -> command emitted, no error.
- Send A4,00,00 -> err code 3, no command. 300 bad sync bytes -> err_cnt_o saturates at 255.
- Assert srst_i after A5,01 -> no command and no error; outputs 0. After reset, A0 -> cmd_valid_o with type 0.
